// File: rtl/inst_fetcher_pkg.sv
// Shared widths, FSM encoding and payload types for the instruction fetcher.
package inst_fetcher_pkg;

  localparam int unsigned AddressWidth    = 32;
  localparam int unsigned IDWidth         = 32;
  localparam int unsigned FetchStateWidth = 2;

  typedef enum logic [FetchStateWidth-1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [IDWidth-1:0]      inst;
    logic [AddressWidth-1:0] pc;
  } fetch_out_t;

  function automatic logic [AddressWidth-1:0] next_pc(input logic [AddressWidth-1:0] pc);
    return AddressWidth'(pc + AddressWidth'(4));
  endfunction

endpackage

// File: rtl/inst_fetcher_icache_array.sv
// Direct-mapped instruction cache storage: one word per line, combinational lookup,
// synchronous single-port fill, valid bits cleared by async reset.
module inst_fetcher_icache_array
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned TAG_BITS   = AddressWidth - INDEX_BITS - 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_BITS-1:0] rd_index_i,
  input  logic [TAG_BITS-1:0]   rd_tag_i,
  output logic                  hit_c_o,
  output logic [IDWidth-1:0]    rd_data_c_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [IDWidth-1:0]    wr_data_i
);

  localparam int unsigned Lines = 2 ** INDEX_BITS;

  logic [Lines-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [Lines];
  logic [IDWidth-1:0]  data_q [Lines];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: a line is only read through its valid bit.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign hit_c_o     = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
  assign rd_data_c_o = data_q[rd_index_i];

endmodule

// File: rtl/inst_fetcher.sv
// PC, fetch FSM and ram_controller handshake in front of a direct-mapped instruction
// cache; hits issue one instruction per cycle, misses fill from memory.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned             INDEX_BITS = 8,
  parameter logic [AddressWidth-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  output logic                    mem_en_out,
  output logic [AddressWidth-1:0] mem_addr_out,
  input  logic                    mem_rdy_in,
  input  logic [IDWidth-1:0]      mem_inst_in,
  input  logic                    stall_in,
  input  logic                    jump_en_in,
  input  logic [AddressWidth-1:0] jump_addr_in,
  output logic                    inst_valid_out,
  output logic [IDWidth-1:0]      inst_out,
  output logic [AddressWidth-1:0] inst_pc_out
);

  localparam int unsigned TagBits  = AddressWidth - INDEX_BITS - 2;
  localparam int unsigned WordBits = AddressWidth - 2;

  fetch_state_e            state_q, state_d;
  logic [AddressWidth-1:0] pc_q, pc_d;
  logic [WordBits-1:0]     fetch_word_q, fetch_word_d;
  fetch_out_t              out_q, out_d;
  logic                    valid_q, valid_d;
  logic                    fill_we;
  logic                    hit;
  logic [IDWidth-1:0]      line_data;

  inst_fetcher_icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TagBits)
  ) u_icache (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .rd_index_i  (pc_q[INDEX_BITS+1:2]),
    .rd_tag_i    (pc_q[AddressWidth-1:INDEX_BITS+2]),
    .hit_c_o     (hit),
    .rd_data_c_o (line_data),
    .we_i        (fill_we),
    .wr_index_i  (fetch_word_q[INDEX_BITS-1:0]),
    .wr_tag_i    (fetch_word_q[WordBits-1:INDEX_BITS]),
    .wr_data_i   (mem_inst_in)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      unique case (state_q)
        IDLE:    if (!jump_en_in && !hit) state_d = WAIT;
        WAIT: begin
          if (mem_rdy_in)      state_d = IDLE;
          else if (jump_en_in) state_d = DISCARD;
        end
        DISCARD: if (mem_rdy_in) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Jump outranks hit and fill; a fill that races a jump still lands but never emits.
  always_comb begin
    pc_d         = pc_q;
    fetch_word_d = fetch_word_q;
    out_d        = out_q;
    valid_d      = valid_q;
    fill_we      = 1'b0;
    if (rdy_in) begin
      valid_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (jump_en_in) begin
            pc_d = jump_addr_in;
          end else if (hit) begin
            if (!stall_in) begin
              valid_d = 1'b1;
              out_d   = '{inst: line_data, pc: pc_q};
              pc_d    = next_pc(pc_q);
            end
          end else begin
            fetch_word_d = pc_q[AddressWidth-1:2];
          end
        end
        WAIT: begin
          fill_we = mem_rdy_in;
          if (jump_en_in) begin
            pc_d = jump_addr_in;
          end else if (mem_rdy_in && !stall_in) begin
            valid_d = 1'b1;
            out_d   = '{inst: mem_inst_in, pc: pc_q};
            pc_d    = next_pc(pc_q);
          end
        end
        DISCARD: begin
          fill_we = mem_rdy_in;
          if (jump_en_in) pc_d = jump_addr_in;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc_q         <= RESET_PC;
      fetch_word_q <= '0;
      out_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      fetch_word_q <= fetch_word_d;
      out_q        <= out_d;
      valid_q      <= valid_d;
    end
  end

  // Dropped during the rdy cycle so the controller does not launch a second fetch.
  assign mem_en_out     = ((state_q == WAIT) || (state_q == DISCARD)) && !mem_rdy_in;
  assign mem_addr_out   = {fetch_word_q, 2'b00};
  assign inst_valid_out = valid_q;
  assign inst_out       = out_q.inst;
  assign inst_pc_out    = out_q.pc;

endmodule

// File: tb/tb_inst_fetcher.sv
// Scoreboard bench for inst_fetcher against a 4-cycle behavioural ram_controller.
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        mem_en_out;
  logic [31:0] mem_addr_out;
  logic        mem_rdy_in = 1'b0;
  logic [31:0] mem_inst_in = 32'h0;
  logic        stall_in;
  logic        jump_en_in;
  logic [31:0] jump_addr_in;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic [31:0] inst_pc_out;

  inst_fetcher dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_en_out     (mem_en_out),
    .mem_addr_out   (mem_addr_out),
    .mem_rdy_in     (mem_rdy_in),
    .mem_inst_in    (mem_inst_in),
    .stall_in       (stall_in),
    .jump_en_in     (jump_en_in),
    .jump_addr_in   (jump_addr_in),
    .inst_valid_out (inst_valid_out),
    .inst_out       (inst_out),
    .inst_pc_out    (inst_pc_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];      // {inst, pc} expected emits
  logic [31:0] exp_req_q[$];  // expected fetch request addresses

  logic [31:0] mem [0:1023];
  bit          busy = 1'b0;
  int          cnt = 0;
  int          req_cnt = 0;
  logic [31:0] lat_addr = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic step();
    @(negedge clk_in);
    #2;
  endtask

  task automatic wait_emit(input int n);
    int seen = 0;
    int budget = 0;
    while (seen < n && budget < 100) begin
      step();
      budget++;
      if (inst_valid_out) seen++;
    end
    if (seen < n) note_fail("emit_timeout");
  endtask

  task automatic wait_cnt(input int c);
    int budget = 0;
    while (!(busy && cnt == c) && budget < 100) begin
      step();
      budget++;
    end
    if (!(busy && cnt == c)) note_fail("request_timeout");
  endtask

  // Behavioural ram_controller inst port: 4-cycle latency, 1-cycle rdy pulse.
  always @(negedge clk_in) begin
    if (rst_in) begin
      busy = 1'b0;
      cnt = 0;
      mem_rdy_in = 1'b0;
    end else if (mem_rdy_in) begin
      mem_rdy_in = 1'b0;
      busy = 1'b0;
    end else if (busy) begin
      check("req_held", 32'(mem_en_out), 32'd1);
      check("req_addr_stable", mem_addr_out, lat_addr);
      cnt++;
      if (cnt == 4) begin
        mem_rdy_in  = 1'b1;
        mem_inst_in = mem[lat_addr[11:2]];
        #1 check("en_drop_in_rdy", 32'(mem_en_out), 32'd0);
      end
    end else if (mem_en_out) begin
      busy = 1'b1;
      cnt = 0;
      lat_addr = mem_addr_out;
      req_cnt++;
      if (exp_req_q.size() == 0) note_fail("unexpected_request");
      else check("req_addr", mem_addr_out, exp_req_q.pop_front());
    end
  end

  // Scoreboard monitor.
  always @(negedge clk_in) begin
    logic [63:0] e;
    if (!rst_in && inst_valid_out) begin
      if (exp_q.size() == 0) begin
        note_fail("unexpected_emit");
      end else begin
        e = exp_q.pop_front();
        check("emit_inst", inst_out, e[63:32]);
        check("emit_pc", inst_pc_out, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int saved_req;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    rst_in = 1'b1;
    rdy_in = 1'b1;
    stall_in = 1'b0;
    jump_en_in = 1'b0;
    jump_addr_in = 32'h0;
    step();
    step();
    check("rst_valid", 32'(inst_valid_out), 32'd0);
    check("rst_inst", inst_out, 32'h0);
    check("rst_pc", inst_pc_out, 32'h0);
    check("rst_en", 32'(mem_en_out), 32'd0);

    // 1: cold start, four misses in order
    exp_req_q.push_back(32'h0);
    exp_req_q.push_back(32'h4);
    exp_req_q.push_back(32'h8);
    exp_req_q.push_back(32'hC);
    exp_q.push_back({32'hC0DE_0000, 32'h0});
    exp_q.push_back({32'hC0DE_0001, 32'h4});
    exp_q.push_back({32'hC0DE_0002, 32'h8});
    exp_q.push_back({32'hC0DE_0003, 32'hC});
    rst_in = 1'b0;
    wait_emit(4);

    // 2: loop back to 0, four consecutive hits
    jump_en_in = 1'b1;
    jump_addr_in = 32'h0;
    exp_q.push_back({32'hC0DE_0000, 32'h0});
    exp_q.push_back({32'hC0DE_0001, 32'h4});
    exp_q.push_back({32'hC0DE_0002, 32'h8});
    exp_q.push_back({32'hC0DE_0003, 32'hC});
    step();
    jump_en_in = 1'b0;
    check("jump_no_emit", 32'(inst_valid_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("hit_stream_valid", 32'(inst_valid_out), 32'd1);
      check("hit_stream_no_req", 32'(mem_en_out), 32'd0);
    end

    // 3: jump to 0x100 two cycles into the miss at 0x10
    exp_req_q.push_back(32'h10);
    wait_cnt(1);
    jump_en_in = 1'b1;
    jump_addr_in = 32'h100;
    exp_req_q.push_back(32'h100);
    exp_q.push_back({32'hC0DE_0040, 32'h100});
    step();
    jump_en_in = 1'b0;
    check("discard_req_held", 32'(mem_en_out), 32'd1);
    check("discard_addr", mem_addr_out, 32'h10);
    wait_emit(1);

    // 4: stall for three cycles across the fill of 0x104
    exp_req_q.push_back(32'h104);
    exp_q.push_back({32'hC0DE_0041, 32'h104});
    wait_cnt(3);
    saved_req = req_cnt;
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_no_emit", 32'(inst_valid_out), 32'd0);
    end
    check("stall_line_hit_no_req", 32'(mem_en_out), 32'd0);
    stall_in = 1'b0;
    step();
    check("release_emit", 32'(inst_valid_out), 32'd1);
    check("release_no_new_req", 32'(req_cnt), 32'(saved_req));

    // 5: alias on index 0 between 0x0 and 0x400
    jump_en_in = 1'b1;
    jump_addr_in = 32'h400;
    exp_req_q.push_back(32'h400);
    exp_q.push_back({32'hC0DE_0100, 32'h400});
    step();
    jump_en_in = 1'b0;
    wait_emit(1);
    jump_en_in = 1'b1;
    jump_addr_in = 32'h0;
    exp_req_q.push_back(32'h0);
    step();
    jump_en_in = 1'b0;
    wait_cnt(1);

    // 6: async reset between edges while in WAIT
    check("pre_reset_en", 32'(mem_en_out), 32'd1);
    #1 rst_in = 1'b1;
    #1;
    check("reset_en_now", 32'(mem_en_out), 32'd0);
    check("reset_valid_now", 32'(inst_valid_out), 32'd0);
    step();
    step();
    rdy_in = 1'b0;
    rst_in = 1'b0;
    saved_req = req_cnt;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rdy_low_hold_en", 32'(mem_en_out), 32'd0);
    end
    check("rdy_low_no_req", 32'(req_cnt), 32'(saved_req));
    exp_req_q.push_back(32'h0);
    exp_req_q.push_back(32'h4);
    exp_q.push_back({32'hC0DE_0000, 32'h0});
    exp_q.push_back({32'hC0DE_0001, 32'h4});
    rdy_in = 1'b1;
    wait_emit(2);

    check("emits_drained", 32'(exp_q.size()), 32'd0);
    check("requests_drained", 32'(exp_req_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
